carrier_nco: RTL and testbench
==============================

# carrier_nco

- Carrier numerically controlled oscillator for the NavIC L1 carrier wipe-off path.
- Keeps an ACC_WIDTH-bit phase accumulator stepped by a programmable frequency control word (FCW).
- Each enabled cycle it emits registered quarter-wave table addresses and negate flags for sine and cosine. These drive the 256-entry Q1.15 quarter-wave sin/cos lookup stage directly downstream.
- Also counts complete carrier cycles for tracking-loop bookkeeping.

## Interface

Parameters:
- ACC_WIDTH, 32: phase accumulator width. Full scale 2^ACC_WIDTH = 2π.
- IDX_WIDTH, 8: quarter-wave table address width. Table depth is 2^IDX_WIDTH = 256.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance the accumulator and emit one output sample.
- fcw_load  in  1  capture fcw_in into the FCW register.
- fcw_in  in  ACC_WIDTH  new frequency control word (unsigned phase step).
- phase_load  in  1  overwrite the accumulator with phase_in.
- phase_in  in  ACC_WIDTH  new phase.
- sin_idx  out  IDX_WIDTH  sine table address.
- sin_neg  out  1  negate the sine table output.
- cos_idx  out  IDX_WIDTH  cosine table address.
- cos_neg  out  1  negate the cosine table output.
- out_valid  out  1  the sin/cos outputs carry a new sample.
- cycle_wrap  out  1  one-cycle pulse when the accumulator overflowed.
- cycle_count  out  16  count of completed carrier cycles, modulo 2^16.

## Operation

**Phase decomposition**
- q = acc[ACC_WIDTH-1 -: 2] (quadrant).
- f = acc[ACC_WIDTH-3 -: IDX_WIDTH] (fine index).
- Lower bits are truncated.

**Quadrant mapping, map(q, f)**
- q=0: idx=f, neg=0.
- q=1: idx=255-f, neg=0.
- q=2: idx=f, neg=1.
- q=3: idx=255-f, neg=1.
- Here 255 means 2^IDX_WIDTH-1.

**Outputs per sample**
- sin_idx and sin_neg = map(q, f).
- cos_idx and cos_neg = map((q+1) mod 4, f), i.e. phase + π/2.

**Enabled cycle** (en=1, phase_load=0), all on the same clock edge:
- Output registers load map() of the current (pre-increment) acc.
- acc <= acc + fcw, modulo 2^ACC_WIDTH.
- out_valid <= 1.
- If the addition carries out: cycle_wrap <= 1 and cycle_count <= cycle_count + 1 (wraps 0xFFFF→0). Otherwise cycle_wrap <= 0.

**Disabled cycle** (en=0)
- acc, fcw, the sin/cos output registers and cycle_count hold.
- out_valid <= 0 and cycle_wrap <= 0.

**Register loads**
- fcw_load: fcw <= fcw_in. It takes effect from the next accumulation. An accumulation in the same cycle uses the old fcw.
- phase_load has priority over en:
  - acc <= phase_in.
  - out_valid <= 0, cycle_wrap <= 0.
  - Output registers and cycle_count hold; no wrap is counted.
- fcw_load and phase_load together: both registers load.

**Special cases**
- fcw=0: the phase is constant and no wrap occurs.
- fcw ≥ 2^(ACC_WIDTH-1) is legal. The phase then advances modulo 2π, with a wrap whenever carry-out occurs.

## Timing

- Latency: the sample for phase P appears one cycle after the en edge that consumes P.
- After phase_load of P followed by en, the first valid sample is map(P).
- Throughput: one sample per clock while en=1.
- cycle_wrap is asserted together with the out_valid sample whose successor phase wrapped.
- Reset (rst=1 at an edge), also when it arrives mid-stream:
  - acc=0, fcw=0, sin_idx=0, sin_neg=0, cos_idx=2^IDX_WIDTH-1, cos_neg=0.
  - out_valid=0, cycle_wrap=0, cycle_count=0.
  - rst overrides en, fcw_load and phase_load.

## Configuration

- Macro: NCO_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps x^16+x^14+x^13+x^11+1) resets to 0xACE1 and advances once per enabled, non-phase_load cycle.
  - Its 16 bits, aligned to the MSB of the truncated field, are added to acc modulo 2^ACC_WIDTH before q and f are extracted.
  - The dither affects the index only. acc, wraps and cycle_count are unaffected.
  - Requires ACC_WIDTH-IDX_WIDTH-2 ≥ 16.
- Undefined: plain truncation and no LFSR logic. All tests below run with the macro undefined.

## Test plan

- Reset, then idle: all outputs at their reset values; cos_idx=255; out_valid=0 for 10 cycles with en=0.
- fcw_load 0x0100_0000, then en held high:
  - samples sin_idx = 0, 4, …, 252 with sin_neg=0;
  - the 65th sample has sin_idx=255, cos_idx=0, cos_neg=1;
  - cycle_wrap pulses with the 256th sample; cycle_count=1 afterwards, 2 after 512 samples.
- phase_load 0x8000_0000, fcw 0, en=1: sin_idx=0, sin_neg=1, cos_idx=255, cos_neg=1, repeated every cycle with no cycle_wrap.
- phase_load 0xC000_0000 asserted in the same cycle as en: out_valid=0 that cycle, no counting. The next sample is sin_idx=255, sin_neg=1, cos_idx=0, cos_neg=0.
- fcw_load 0x0200_0000 mid-stream with en=1: the step of 4 still applies to the immediately following sample, and a step of 8 to the one after.
- rst pulsed mid-stream with cycle_count=5: the next cycle shows all reset values. Restarting at fcw 0x0100_0000 reproduces the second scenario's sequence exactly.

Source files
------------

// File: rtl/carrier_nco.sv
// Carrier NCO: phase accumulator driving quarter-wave sin/cos table addresses, plus a carrier-cycle counter.
// Optional index dither enabled by defining NCO_DITHER_EN (needs ACC_WIDTH-IDX_WIDTH-2 >= 16).
module carrier_nco #(
  parameter int ACC_WIDTH = 32,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fcw_load,
  input  logic [ACC_WIDTH-1:0] fcw_in,
  input  logic                 phase_load,
  input  logic [ACC_WIDTH-1:0] phase_in,
  output logic [IDX_WIDTH-1:0] sin_idx,
  output logic                 sin_neg,
  output logic [IDX_WIDTH-1:0] cos_idx,
  output logic                 cos_neg,
  output logic                 out_valid,
  output logic                 cycle_wrap,
  output logic [15:0]          cycle_count
);

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] fcw_reg;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 advance;
  logic [1:0]           quadrant;
  logic [IDX_WIDTH-1:0] fine;

  // Index 0 is sine, index 1 is cosine (quadrant advanced by pi/2).
  logic [1:0][IDX_WIDTH-1:0] idx_next;
  logic [1:0]                neg_next;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, fcw_reg};
  assign advance = en & ~phase_load;

`ifdef NCO_DITHER_EN
  localparam int DITHER_SHIFT = ACC_WIDTH - IDX_WIDTH - 2 - 16;

  logic [15:0]          lfsr_reg;
  logic                 lfsr_fb;
  logic [ACC_WIDTH-1:0] lookup_phase;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else if (advance) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  // Dither only perturbs the table lookup; the accumulator itself is untouched.
  assign lookup_phase = acc_reg + (ACC_WIDTH'(lfsr_reg) << DITHER_SHIFT);
  assign quadrant     = lookup_phase[ACC_WIDTH-1 -: 2];
  assign fine         = lookup_phase[ACC_WIDTH-3 -: IDX_WIDTH];
`else
  assign quadrant = acc_reg[ACC_WIDTH-1 -: 2];
  assign fine     = acc_reg[ACC_WIDTH-3 -: IDX_WIDTH];
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_map
      logic [1:0] quad_rot;
      assign quad_rot     = quadrant + 2'(gi);
      // Odd quadrants walk the quarter table backwards; upper half negates.
      assign idx_next[gi] = quad_rot[0] ? ~fine : fine;
      assign neg_next[gi] = quad_rot[1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      fcw_reg     <= '0;
      sin_idx     <= '0;
      sin_neg     <= 1'b0;
      cos_idx     <= '1;
      cos_neg     <= 1'b0;
      out_valid   <= 1'b0;
      cycle_wrap  <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (fcw_load) begin
        fcw_reg <= fcw_in;
      end
      if (phase_load) begin
        acc_reg    <= phase_in;
        out_valid  <= 1'b0;
        cycle_wrap <= 1'b0;
      end else if (en) begin
        acc_reg    <= acc_sum[ACC_WIDTH-1:0];
        sin_idx    <= idx_next[0];
        sin_neg    <= neg_next[0];
        cos_idx    <= idx_next[1];
        cos_neg    <= neg_next[1];
        out_valid  <= 1'b1;
        cycle_wrap <= acc_sum[ACC_WIDTH];
        if (acc_sum[ACC_WIDTH]) begin
          cycle_count <= cycle_count + 16'd1;
        end
      end else begin
        out_valid  <= 1'b0;
        cycle_wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_carrier_nco.sv
// Self-checking bench for carrier_nco: a reference model fills a scoreboard queue that a monitor drains.
module tb_carrier_nco;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fcw_load;
  logic [31:0] fcw_in;
  logic        phase_load;
  logic [31:0] phase_in;
  logic [7:0]  sin_idx;
  logic        sin_neg;
  logic [7:0]  cos_idx;
  logic        cos_neg;
  logic        out_valid;
  logic        cycle_wrap;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  carrier_nco #(.ACC_WIDTH(32), .IDX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fcw_load(fcw_load), .fcw_in(fcw_in),
    .phase_load(phase_load), .phase_in(phase_in),
    .sin_idx(sin_idx), .sin_neg(sin_neg),
    .cos_idx(cos_idx), .cos_neg(cos_neg),
    .out_valid(out_valid), .cycle_wrap(cycle_wrap), .cycle_count(cycle_count)
  );

  typedef struct packed {
    logic [7:0]  si;
    logic        sn;
    logic [7:0]  ci;
    logic        cn;
    logic        v;
    logic        w;
    logic [15:0] cc;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  logic [31:0] m_acc;
  logic [31:0] m_fcw;
  int          errors = 0;
  int          checks = 0;

  function automatic void ref_map(input logic [31:0] a, input int shift,
                                  output logic [7:0] idx, output logic neg);
    int q;
    logic [7:0] f;
    q   = (int'(a[31:30]) + shift) % 4;
    f   = a[29:22];
    idx = (q == 1 || q == 3) ? 8'(255 - int'(f)) : f;
    neg = (q >= 2);
  endfunction

  // Drive one cycle of inputs and push the model's expected outputs for that edge.
  task automatic drive(input logic r, input logic e, input logic fl, input logic [31:0] fi,
                       input logic pl, input logic [31:0] pi);
    logic [32:0] s;
    logic [31:0] nf;
    logic [7:0]  ix;
    logic        ng;
    @(negedge clk);
    rst = r; en = e; fcw_load = fl; fcw_in = fi; phase_load = pl; phase_in = pi;
    if (r) begin
      m_acc = '0;
      m_fcw = '0;
      m     = '0;
      m.ci  = 8'hFF;
    end else begin
      nf = fl ? fi : m_fcw;
      if (pl) begin
        m_acc = pi;
        m.v   = 1'b0;
        m.w   = 1'b0;
      end else if (e) begin
        ref_map(m_acc, 0, ix, ng);
        m.si = ix; m.sn = ng;
        ref_map(m_acc, 1, ix, ng);
        m.ci = ix; m.cn = ng;
        s     = {1'b0, m_acc} + {1'b0, m_fcw};
        m_acc = s[31:0];
        m.v   = 1'b1;
        m.w   = s[32];
        if (s[32]) m.cc = m.cc + 16'd1;
      end else begin
        m.v = 1'b0;
        m.w = 1'b0;
      end
      m_fcw = nf;
    end
    sb.push_back(m);
  endtask

  always begin
    exp_t e_item;
    exp_t a_item;
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      e_item = sb.pop_front();
      a_item = {sin_idx, sin_neg, cos_idx, cos_neg, out_valid, cycle_wrap, cycle_count};
      checks++;
      if (a_item !== e_item) begin
        errors++;
        $display("FAIL scoreboard: got %h expected %h (si,sn,ci,cn,v,w,cc)", a_item, e_item);
      end
    end
  end

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if ({sin_idx, sin_neg, cos_idx, cos_neg, out_valid, cycle_wrap, cycle_count} !==
        {8'd0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got si=%0d sn=%0b ci=%0d cn=%0b v=%0b w=%0b cc=%0d required 0 0 255 0 0 0 0",
               sin_idx, sin_neg, cos_idx, cos_neg, out_valid, cycle_wrap, cycle_count);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || cos_idx !== 8'd255) begin
        errors++;
        $display("FAIL idle_%0d: got valid=%0b cos_idx=%0d required valid=0 cos_idx=255", i, out_valid, cos_idx);
      end
    end
  endtask

  task automatic test_ramp();
    drive(0, 0, 1, 32'h0100_0000, 0, 0);
    for (int k = 0; k < 512; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      if (k < 64) begin
        checks++;
        if ({sin_idx, sin_neg} !== {8'(4 * k), 1'b0}) begin
          errors++;
          $display("FAIL ramp_%0d: got sin_idx=%0d sin_neg=%0b required %0d 0", k, sin_idx, sin_neg, 4 * k);
        end
      end
      if (k == 64) begin
        checks++;
        if ({sin_idx, cos_idx, cos_neg} !== {8'd255, 8'd0, 1'b1}) begin
          errors++;
          $display("FAIL ramp_quadrant: got sin_idx=%0d cos_idx=%0d cos_neg=%0b required 255 0 1", sin_idx, cos_idx, cos_neg);
        end
      end
      if (k == 254 || k == 255) begin
        checks++;
        if (cycle_wrap !== (k == 255)) begin
          errors++;
          $display("FAIL ramp_wrap_%0d: got cycle_wrap=%0b required %0b", k, cycle_wrap, k == 255);
        end
      end
      if (k == 255 || k == 511) begin
        checks++;
        if (cycle_count !== 16'((k + 1) / 256)) begin
          errors++;
          $display("FAIL ramp_count_%0d: got %0d required %0d", k, cycle_count, (k + 1) / 256);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_const_phase();
    drive(0, 0, 1, 32'h0, 1, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      checks++;
      if ({sin_idx, sin_neg, cos_idx, cos_neg, cycle_wrap} !== {8'd0, 1'b1, 8'd255, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL const_phase_%0d: got si=%0d sn=%0b ci=%0d cn=%0b w=%0b required 0 1 255 1 0",
                 i, sin_idx, sin_neg, cos_idx, cos_neg, cycle_wrap);
      end
    end
  endtask

  task automatic test_load_with_en();
    drive(0, 1, 1, 32'h0100_0000, 1, 32'hC000_0000);
    @(posedge clk); #1;
    checks++;
    if ({out_valid, cycle_wrap, cycle_count} !== {1'b0, 1'b0, 16'd2}) begin
      errors++;
      $display("FAIL load_priority: got v=%0b w=%0b cc=%0d required 0 0 2", out_valid, cycle_wrap, cycle_count);
    end
    drive(0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if ({sin_idx, sin_neg, cos_idx, cos_neg} !== {8'd255, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL load_first_sample: got si=%0d sn=%0b ci=%0d cn=%0b required 255 1 0 0",
               sin_idx, sin_neg, cos_idx, cos_neg);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fcw_change();
    logic [7:0] want [4];
    want[0] = 8'd0; want[1] = 8'd4; want[2] = 8'd8; want[3] = 8'd16;
    drive(0, 0, 1, 32'h0100_0000, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 1), 32'h0200_0000, 0, 0);
      @(posedge clk); #1;
      checks++;
      if (sin_idx !== want[i]) begin
        errors++;
        $display("FAIL fcw_change_%0d: got sin_idx=%0d required %0d", i, sin_idx, want[i]);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h8000_0000, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (cycle_count !== 16'd5) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d required 5", cycle_count);
    end
    drive(1, 1, 1, 32'h1234_5678, 1, 32'h4000_0000);
    @(posedge clk); #1;
    checks++;
    if ({sin_idx, sin_neg, cos_idx, cos_neg, out_valid, cycle_wrap, cycle_count} !==
        {8'd0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL mid_reset: got si=%0d sn=%0b ci=%0d cn=%0b v=%0b w=%0b cc=%0d required 0 0 255 0 0 0 0",
               sin_idx, sin_neg, cos_idx, cos_neg, out_valid, cycle_wrap, cycle_count);
    end
    test_ramp();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fcw_load = 1'b0; fcw_in = '0; phase_load = 1'b0; phase_in = '0;
    test_reset();
    test_ramp();
    test_const_phase();
    test_load_with_en();
    test_fcw_change();
    test_reset_mid();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
